fifo_scheduler: RTL and testbench

FIFO_SCHEDULER -- requirements
Module: fifo_scheduler

---
 rtl/fifo_scheduler.sv | 158 +++++++++++++++
 tb/tb_fifo_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_scheduler.sv
// fifo_scheduler: moves words from four source FIFOs to four destination FIFOs.
// A round-robin arbiter pops one source per cycle while the block is ACTIVE and
// no destination is almost full. The popped word appears on in_data one cycle
// later, is captured, and is pushed the following cycle to the destination
// selected by its top two bits. The block also owns the almost-empty and
// almost-full thresholds shared by all eight FIFOs, loaded while in INIT.
//
// Ports
//   clk, reset_L                 clock, asynchronous active-low reset
//   init                         request (re)configuration
//   empty/full_threshold_in      threshold values captured during INIT
//   in_empty, in_data            source FIFO empty flags and output words
//   out_almost_full, out_empty   destination FIFO status
//   fifo_error                   error flags ([3:0] sources, [7:4] destinations)
//   in_rd, out_wr, out_data      one-hot pop, one-hot push, pushed word
//   empty/full_threshold         registered thresholds driven to all FIFOs
//   state, idle, error_out       FSM state code and status flags
module fifo_scheduler #(
    parameter int unsigned WORD_SIZE = 6,
    parameter int unsigned PTR_L     = 3
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   init,
    input  logic [PTR_L-1:0]       empty_threshold_in,
    input  logic [PTR_L-1:0]       full_threshold_in,
    input  logic [3:0]             in_empty,
    input  logic [4*WORD_SIZE-1:0] in_data,
    input  logic [3:0]             out_almost_full,
    input  logic [3:0]             out_empty,
    input  logic [7:0]             fifo_error,
    output logic [3:0]             in_rd,
    output logic [3:0]             out_wr,
    output logic [WORD_SIZE-1:0]   out_data,
    output logic [PTR_L-1:0]       empty_threshold,
    output logic [PTR_L-1:0]       full_threshold,
    output logic [2:0]             state,
    output logic                   idle,
    output logic                   error_out
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [PTR_L-1:0]     empty_th_q, empty_th_d;
    logic [PTR_L-1:0]     full_th_q, full_th_d;
    // Stage 1: a pop was issued last cycle from rd_src_q.
    logic                 rd_valid_q, rd_valid_d;
    logic [1:0]           rd_src_q, rd_src_d;
    // Stage 2: captured word, pushed this cycle.
    logic                 word_valid_q, word_valid_d;
    logic [WORD_SIZE-1:0] word_q, word_d;

    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       pop;
    logic       in_flight;
    logic       flush;
    logic [1:0] dest;

    // Round-robin: first non-empty source at or after the pointer, wrapping mod 4.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (!in_empty[ptr_q + 2'(k)]) begin
                grant_valid = 1'b1;
                grant_idx   = ptr_q + 2'(k);
            end
        end
    end

    assign pop       = (state_q == StActive) && grant_valid && (out_almost_full == 4'b0000);
    assign in_flight = rd_valid_q | word_valid_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StInit;
            StInit: begin
                if (|fifo_error) state_d = StError;
                else if (!init)  state_d = StIdle;
            end
            StIdle: begin
                if (|fifo_error)     state_d = StError;
                else if (init)       state_d = StInit;
                else if (~&in_empty) state_d = StActive;
            end
            StActive: begin
                if (|fifo_error)                  state_d = StError;
                else if (init)                    state_d = StInit;
                else if (&in_empty && !in_flight) state_d = StIdle;
            end
            StError:  state_d = StError;
            default:  state_d = StReset;
        endcase
    end

    // Words still in the pipeline finish their push unless the block is erroring out.
    assign flush = (state_d == StError) || (state_q == StError);

    always_comb begin
        ptr_d        = pop ? grant_idx + 2'd1 : ptr_q;
        empty_th_d   = (state_q == StInit) ? empty_threshold_in : empty_th_q;
        full_th_d    = (state_q == StInit) ? full_threshold_in : full_th_q;
        rd_valid_d   = pop && !flush;
        rd_src_d     = pop ? grant_idx : rd_src_q;
        word_valid_d = rd_valid_q && !flush;
        word_d       = word_q;
        if (rd_valid_q && !flush) begin
            word_d = in_data[int'(rd_src_q) * WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StReset;
            ptr_q        <= 2'd0;
            empty_th_q   <= PTR_L'(1);
            full_th_q    <= PTR_L'(3);
            rd_valid_q   <= 1'b0;
            rd_src_q     <= 2'd0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            empty_th_q   <= empty_th_d;
            full_th_q    <= full_th_d;
            rd_valid_q   <= rd_valid_d;
            rd_src_q     <= rd_src_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign dest = word_q[WORD_SIZE-1 -: 2];

    always_comb begin
        in_rd  = pop ? (4'b0001 << grant_idx) : 4'b0000;
        out_wr = (word_valid_q && (state_q != StError)) ? (4'b0001 << dest) : 4'b0000;
    end

    assign out_data        = word_q;
    assign empty_threshold = empty_th_q;
    assign full_threshold  = full_th_q;
    assign state           = state_q;
    assign error_out       = (state_q == StError);
    assign idle            = (state_q == StIdle) && (&in_empty) && (&out_empty) && !in_flight;

endmodule

// File: tb/tb_fifo_scheduler.sv
// Testbench for fifo_scheduler: a cycle-by-cycle vector table covering configuration,
// a single transfer, round-robin streaming, back-pressure, error entry and reset
// during a transfer, followed by a hand-written init-during-transfer sequence.
module tb_fifo_scheduler;

    localparam int unsigned W = 6;
    localparam int unsigned P = 3;

    logic           clk;
    logic           reset_L;
    logic           init;
    logic [P-1:0]   empty_threshold_in;
    logic [P-1:0]   full_threshold_in;
    logic [3:0]     in_empty;
    logic [4*W-1:0] in_data;
    logic [3:0]     out_almost_full;
    logic [3:0]     out_empty;
    logic [7:0]     fifo_error;
    logic [3:0]     in_rd;
    logic [3:0]     out_wr;
    logic [W-1:0]   out_data;
    logic [P-1:0]   empty_threshold;
    logic [P-1:0]   full_threshold;
    logic [2:0]     state;
    logic           idle;
    logic           error_out;

    fifo_scheduler #(.WORD_SIZE(W), .PTR_L(P)) dut (
        .clk                (clk),
        .reset_L            (reset_L),
        .init               (init),
        .empty_threshold_in (empty_threshold_in),
        .full_threshold_in  (full_threshold_in),
        .in_empty           (in_empty),
        .in_data            (in_data),
        .out_almost_full    (out_almost_full),
        .out_empty          (out_empty),
        .fifo_error         (fifo_error),
        .in_rd              (in_rd),
        .out_wr             (out_wr),
        .out_data           (out_data),
        .empty_threshold    (empty_threshold),
        .full_threshold     (full_threshold),
        .state              (state),
        .idle               (idle),
        .error_out          (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         init;
        logic [3:0]   ie;
        logic [23:0]  idata;
        logic [3:0]   oaf;
        logic [3:0]   oe;
        logic [7:0]   err;
        logic [3:0]   rd;
        logic [3:0]   wr;
        logic [5:0]   data;
        logic [2:0]   st;
        logic         idl;
        logic         eo;
        logic [2:0]   eth;
        logic [2:0]   fth;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic rst_n, logic ini, logic [3:0] ie, logic [23:0] idata,
                                logic [3:0] oaf, logic [3:0] oe, logic [7:0] err,
                                logic [3:0] rd, logic [3:0] wr, logic [5:0] data,
                                logic [2:0] st, logic idl, logic eo,
                                logic [2:0] eth, logic [2:0] fth);
        vec_t v;
        v.rst_n = rst_n; v.init = ini; v.ie = ie; v.idata = idata; v.oaf = oaf; v.oe = oe;
        v.err = err; v.rd = rd; v.wr = wr; v.data = data; v.st = st; v.idl = idl;
        v.eo = eo; v.eth = eth; v.fth = fth;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // {in_rd, out_wr, out_data, state, idle, error_out, empty_th, full_th}
    function automatic logic [63:0] pack_out();
        return 64'({in_rd, out_wr, out_data, state, idle, error_out,
                    empty_threshold, full_threshold});
    endfunction

    function automatic logic [63:0] pack_exp(vec_t v);
        return 64'({v.rd, v.wr, v.data, v.st, v.idl, v.eo, v.eth, v.fth});
    endfunction

    localparam logic [23:0] S   = {6'h34, 6'h23, 6'h12, 6'h01};
    localparam logic [23:0] D25 = {6'h00, 6'h25, 12'h000};
    localparam logic [23:0] D0F = {12'h000, 6'h0F, 6'h00};
    localparam logic [23:0] Z   = 24'h0;

    initial begin
        int waited;

        // Configuration from reset: RESET -> INIT (load 2/2) -> IDLE.
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 1, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     1, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     2, 1, 0, 2, 2));
        // Single word 6'h25 from source 2, pushed to destination 2 two cycles after pop.
        vecs.push_back(mk(1, 0, 4'hB, D25, 0, 4'hF, 0,     0, 0, 0,     2, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hB, D25, 0, 4'hF, 0,     4'h4, 0, 0,  3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hF, D25, 0, 4'hF, 0,     0, 0, 0,     3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 4'h4, 6'h25, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 6'h25, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 6'h25, 2, 1, 0, 2, 2));
        // Reset so the pointer restarts at 0, then stream from all four sources.
        vecs.push_back(mk(0, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,     1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     0, 0, 0,     2, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h1, 0, 0,     3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h2, 0, 0,     3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h4, 4'h1, 6'h01, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h8, 4'h2, 6'h12, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h1, 4'h4, 6'h23, 3, 0, 0, 2, 2));
        // Destination 1 almost full for three cycles: no pops, pipeline drains.
        vecs.push_back(mk(1, 0, 4'h0, S,   2, 4'hF, 0,     0, 4'h8, 6'h34, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   2, 4'hF, 0,     0, 4'h1, 6'h01, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   2, 4'hF, 0,     0, 0, 6'h01,    3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h2, 0, 6'h01, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     4'h4, 0, 6'h01, 3, 0, 0, 2, 2));
        // Destination error while streaming: ERROR next cycle, sticky, pending push dropped.
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 8'h20, 4'h8, 4'h2, 6'h12, 3, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'h0, S,   0, 4'hF, 0,     0, 0, 6'h12,    4, 0, 1, 2, 2));
        vecs.push_back(mk(1, 1, 4'h0, S,   0, 4'hF, 0,     0, 0, 6'h12,    4, 0, 1, 2, 2));
        vecs.push_back(mk(0, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,        0, 0, 0, 1, 3));
        // Reset one cycle after a pop: the in-flight word must never be pushed.
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,        0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, Z,   0, 4'hF, 0,     0, 0, 0,        1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hE, S,   0, 4'hF, 0,     0, 0, 0,        2, 0, 0, 2, 2));
        vecs.push_back(mk(1, 0, 4'hE, S,   0, 4'hF, 0,     4'h1, 0, 0,     3, 0, 0, 2, 2));
        vecs.push_back(mk(0, 0, 4'hF, S,   0, 4'hF, 0,     0, 0, 0,        0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, S,   0, 4'hF, 0,     0, 0, 0,        0, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, S,   0, 4'hF, 0,     0, 0, 0,        1, 0, 0, 1, 3));
        vecs.push_back(mk(1, 0, 4'hF, S,   0, 4'hF, 0,     0, 0, 0,        2, 1, 0, 2, 2));

        reset_L            = 1'b0;
        init               = 1'b0;
        empty_threshold_in = 3'd2;
        full_threshold_in  = 3'd2;
        in_empty           = 4'hF;
        in_data            = '0;
        out_almost_full    = 4'h0;
        out_empty          = 4'hF;
        fifo_error         = 8'h0;

        repeat (2) @(negedge clk);
        check("reset_values", pack_out(), 64'({4'h0, 4'h0, 6'h00, 3'd0, 1'b0, 1'b0, 3'd1, 3'd3}));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset_L         = vecs[i].rst_n;
            init            = vecs[i].init;
            in_empty        = vecs[i].ie;
            in_data         = vecs[i].idata;
            out_almost_full = vecs[i].oaf;
            out_empty       = vecs[i].oe;
            fifo_error      = vecs[i].err;
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
        end

        // init raised the cycle after a pop: the word still gets pushed while in INIT,
        // and the new thresholds 5/6 are loaded.
        @(posedge clk); #1;
        in_empty = 4'hD;
        in_data  = D0F;
        @(posedge clk); #1;
        @(negedge clk);
        check("init_seq_pop", 64'(in_rd), 64'(4'h2));
        @(posedge clk); #1;
        in_empty           = 4'hF;
        init               = 1'b1;
        empty_threshold_in = 3'd5;
        full_threshold_in  = 3'd6;
        waited = 0;
        @(negedge clk);
        while (out_wr == 4'h0 && waited < 6) begin
            @(posedge clk); #1;
            waited++;
            @(negedge clk);
        end
        check("init_seq_push_latency", 64'(waited), 64'(1));
        check("init_seq_push", 64'({out_wr, out_data}), 64'({4'h1, 6'h0F}));
        check("init_seq_state", 64'(state), 64'(3'd1));
        @(posedge clk); #1;
        init = 1'b0;
        @(negedge clk);
        check("init_seq_thresholds", 64'({state, empty_threshold, full_threshold, out_wr}),
              64'({3'd1, 3'd5, 3'd6, 4'h0}));
        @(posedge clk); #1;
        @(negedge clk);
        check("init_seq_idle", 64'({state, idle}), 64'({3'd2, 1'b1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
